// File: rtl/mac8_operand_sequencer.sv
// Assembles (A,B) operand pairs from a pin-side byte stream into a small FIFO
// and issues them to MAC8 over a valid/ready handshake, framing each burst.
module mac8_operand_sequencer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     SYS_CLK,
    input  logic                     SYS_RST,
    input  logic [DATA_W-1:0]        in_byte,
    input  logic                     in_strobe,
    input  logic                     in_is_cmd,
    output logic                     in_ready,
    output logic [DATA_W-1:0]        A,
    output logic [DATA_W-1:0]        B,
    output logic                     mac_valid,
    input  logic                     mac_ready,
    output logic                     mac_clear,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     err_protocol,
    output logic                     err_overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_LOAD_A = 3'd2,
        S_LOAD_B = 3'd3,
        S_DRAIN  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t             r_state;
    logic [DATA_W-1:0]  r_remaining;
    logic [DATA_W-1:0]  r_hold_a;
    logic               r_mac_clear;
    logic               r_done;
    logic               r_err_protocol;
    logic               r_err_overflow;

    logic [DATA_W-1:0]  r_mem_a [DEPTH];
    logic [DATA_W-1:0]  r_mem_b [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_full;
    logic               w_empty;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    // LOAD_B refuses bytes while full, so a push never coincides with a full FIFO.
    always_comb begin
        w_in_ready = 1'b0;
        case (r_state)
            S_IDLE:   w_in_ready = 1'b1;
            S_LOAD_A: w_in_ready = 1'b1;
            S_LOAD_B: w_in_ready = !w_full;
            default:  w_in_ready = 1'b0;
        endcase
    end

    assign w_accept = in_strobe && w_in_ready;
    assign w_push   = w_accept && !in_is_cmd && (r_state == S_LOAD_B);
    assign w_pop    = !w_empty && mac_ready;

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            r_state        <= S_IDLE;
            r_remaining    <= '0;
            r_mac_clear    <= 1'b0;
            r_done         <= 1'b0;
            r_err_protocol <= 1'b0;
            r_err_overflow <= 1'b0;
        end else begin
            r_mac_clear <= 1'b0;
            r_done      <= 1'b0;
            if (in_strobe && !w_in_ready) begin
                r_err_overflow <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (!in_is_cmd) begin
                            r_err_protocol <= 1'b1;
                        end else begin
                            // An empty burst still frames the accumulator: clear and done together.
                            r_mac_clear <= 1'b1;
                            if (in_byte == '0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_remaining <= in_byte;
                                r_state     <= S_CLEAR;
                            end
                        end
                    end
                end
                S_CLEAR: r_state <= S_LOAD_A;
                S_LOAD_A: begin
                    if (w_accept) begin
                        if (in_is_cmd) begin
                            r_err_protocol <= 1'b1;
                        end else begin
                            r_state <= S_LOAD_B;
                        end
                    end
                end
                S_LOAD_B: begin
                    if (w_accept) begin
                        if (in_is_cmd) begin
                            r_err_protocol <= 1'b1;
                        end else begin
                            r_remaining <= r_remaining - DATA_W'(1);
                            r_state     <= (r_remaining == DATA_W'(1)) ? S_DRAIN : S_LOAD_A;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_empty) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Operand data carries no reset; only the hold register and FIFO payload.
    always_ff @(posedge SYS_CLK) begin
        if ((r_state == S_LOAD_A) && w_accept && !in_is_cmd) begin
            r_hold_a <= in_byte;
        end
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= r_hold_a;
            r_mem_b[r_wr_ptr] <= in_byte;
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head entry is masked to zero when empty so A/B read 0 out of reset.
    assign mac_valid    = !w_empty;
    assign A            = mac_valid ? r_mem_a[r_rd_ptr] : '0;
    assign B            = mac_valid ? r_mem_b[r_rd_ptr] : '0;
    assign in_ready     = w_in_ready;
    assign mac_clear    = r_mac_clear;
    assign done         = r_done;
    assign busy         = (r_state != S_IDLE);
    assign fifo_count   = r_count;
    assign err_protocol = r_err_protocol;
    assign err_overflow = r_err_overflow;
endmodule

// File: tb/tb_mac8_operand_sequencer.sv
// Directed bench for mac8_operand_sequencer with a pair scoreboard on the issue side.
module tb_mac8_operand_sequencer;
    logic       SYS_CLK = 1'b0;
    logic       SYS_RST = 1'b1;
    logic [7:0] in_byte = '0;
    logic       in_strobe = 1'b0;
    logic       in_is_cmd = 1'b0;
    logic       in_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic       mac_valid;
    logic       mac_ready = 1'b0;
    logic       mac_clear;
    logic       busy;
    logic       done;
    logic [2:0] fifo_count;
    logic       err_protocol;
    logic       err_overflow;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] sb_q[$];

    mac8_operand_sequencer #(.DATA_W(8), .DEPTH(4)) dut (
        .SYS_CLK(SYS_CLK), .SYS_RST(SYS_RST), .in_byte(in_byte), .in_strobe(in_strobe),
        .in_is_cmd(in_is_cmd), .in_ready(in_ready), .A(A), .B(B), .mac_valid(mac_valid),
        .mac_ready(mac_ready), .mac_clear(mac_clear), .busy(busy), .done(done),
        .fifo_count(fifo_count), .err_protocol(err_protocol), .err_overflow(err_overflow)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue-side monitor: a handshake seen at the falling edge is consumed at the next rising edge.
    always @(negedge SYS_CLK) begin
        if (!SYS_RST && mac_valid && mac_ready) begin
            check("pop_has_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                check("pair_AB", {16'd0, A, B}, {16'd0, sb_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge SYS_CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic c);
        int k;
        k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        in_byte   = b;
        in_is_cmd = c;
        in_strobe = 1'b1;
        tick();
        in_strobe = 1'b0;
    endtask

    task automatic send_pair(input logic [7:0] a, input logic [7:0] b);
        send(a, 1'b0);
        send(b, 1'b0);
        sb_q.push_back({a, b});
    endtask

    task automatic wait_done(input string tag);
        int k;
        logic seen;
        seen = 1'b0;
        k = 0;
        while (!seen && k < 60) begin
            tick();
            seen = done;
            k++;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_others"},
              {8'd0, A, B, mac_valid, mac_clear, busy, done, fifo_count, err_protocol, err_overflow},
              32'd0);
    endtask

    initial begin
        // Reset
        SYS_RST = 1'b1;
        tick();
        tick();
        check_reset_outputs("reset");
        SYS_RST = 1'b0;

        // 1: basic two-pair burst, MAC always ready
        mac_ready = 1'b1;
        send(8'd2, 1'b1);
        check("t1_clear", 32'(mac_clear), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_no_valid_during_clear", 32'(mac_valid), 32'd0);
        send_pair(8'd3, 8'd4);
        send_pair(8'd5, 8'd6);
        wait_done("t1_done");
        tick();
        check("t1_idle", {30'd0, busy, done}, 32'd0);
        check("t1_sb_empty", 32'(sb_q.size()), 32'd0);

        // 2: fill FIFO with MAC stalled, then overflow strobe
        mac_ready = 1'b0;
        send(8'd6, 1'b1);
        for (int i = 0; i < 4; i++) begin
            send_pair(8'h10 + 8'(2 * i), 8'h11 + 8'(2 * i));
        end
        send(8'h18, 1'b0);
        check("t2_count_full", 32'(fifo_count), 32'd4);
        check("t2_in_ready_low", 32'(in_ready), 32'd0);
        check("t2_no_ovf_yet", 32'(err_overflow), 32'd0);
        in_byte   = 8'hEE;
        in_is_cmd = 1'b0;
        in_strobe = 1'b1;
        tick();
        in_strobe = 1'b0;
        check("t2_err_overflow", 32'(err_overflow), 32'd1);
        check("t2_count_held", 32'(fifo_count), 32'd4);

        // 3: stall with valid asserted, head must hold
        for (int i = 0; i < 5; i++) begin
            check("t3_stable", {15'd0, mac_valid, A, B}, {15'd0, 1'b1, 8'h10, 8'h11});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_stable_cyc", {12'd0, fifo_count, mac_valid, A, B}, {12'd0, 3'd4, 1'b1, 8'h10, 8'h11});
        end
        mac_ready = 1'b1;
        tick();
        check("t3_one_pop", 32'(fifo_count), 32'd3);
        send(8'h19, 1'b0);
        sb_q.push_back({8'h18, 8'h19});
        send_pair(8'h1A, 8'h1B);
        wait_done("t2_done");
        check("t2_sb_empty", 32'(sb_q.size()), 32'd0);
        check("t2_ovf_sticky", 32'(err_overflow), 32'd1);

        // 4: zero-length burst
        tick();
        send(8'd0, 1'b1);
        check("t4_clear_done", {30'd0, mac_clear, done}, 32'd3);
        check("t4_no_busy_valid", {30'd0, busy, mac_valid}, 32'd0);
        tick();
        check("t4_pulses_end", {30'd0, mac_clear, done}, 32'd0);

        // 5: protocol errors
        SYS_RST = 1'b1;
        tick();
        SYS_RST = 1'b0;
        send(8'h55, 1'b0);
        check("t5_err_protocol", 32'(err_protocol), 32'd1);
        check("t5_fifo_empty", {28'd0, fifo_count, busy}, 32'd0);
        send(8'd1, 1'b1);
        send(8'd7, 1'b0);
        send(8'd9, 1'b1);
        check("t5_cmd_ignored", {28'd0, fifo_count, busy}, 32'd1);
        send(8'd8, 1'b0);
        sb_q.push_back({8'd7, 8'd8});
        wait_done("t5_done");
        check("t5_sb_empty", 32'(sb_q.size()), 32'd0);

        // 6: reset mid-burst, then a clean burst
        mac_ready = 1'b0;
        send(8'd3, 1'b1);
        send(8'd1, 1'b0);
        send(8'd2, 1'b0);
        send(8'd3, 1'b0);
        check("t6_one_pair", 32'(fifo_count), 32'd1);
        SYS_RST = 1'b1;
        tick();
        sb_q.delete();
        check_reset_outputs("t6_reset");
        SYS_RST = 1'b0;
        mac_ready = 1'b1;
        send(8'd1, 1'b1);
        check("t6_clear", 32'(mac_clear), 32'd1);
        send_pair(8'hAA, 8'hBB);
        wait_done("t6_done");
        tick();
        check("t6_sb_empty", 32'(sb_q.size()), 32'd0);
        check("t6_idle", {30'd0, busy, mac_valid}, 32'd0);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
